ppi_mode1_handshake: RTL

Strobed-handshake port stage that sits directly downstream of the PPI mode/case data path. It implements 8255-style Mode 1 behaviour for one 8-bit port group (A or B): input latching on STB_N with IBF/INTR, or output latching with OBF_N/ACK_N/INTR. The data path drives CPU-side read/write pulses and control bits. This block drives the external port pins and the Port C status bits.

---
 rtl/ppi_mode1_handshake.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ppi_mode1_handshake.sv
// 8255-style Mode 1 strobed handshake for one port group: input latch (STB_N/IBF) or output latch (OBF_N/ACK_N).
// Pin edges act SYNC_STAGES+1 clocks after first sample; CPU pulses act next clock; no backpressure, an early strobe overwrites and flags OVR.
module ppi_mode1_handshake #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             MODE1_EN,
    input  logic             DIR_IN,
    input  logic             INTE,
    input  logic             CPU_RD,
    input  logic             CPU_WR,
    input  logic [WIDTH-1:0] CPU_DIN,
    output logic [WIDTH-1:0] CPU_DOUT,
    input  logic [WIDTH-1:0] PORT_IN,
    output logic [WIDTH-1:0] PORT_OUT,
    output logic             PORT_OE,
    input  logic             STB_N,
    input  logic             ACK_N,
    output logic             IBF,
    output logic             OBF_N,
    output logic             INTR,
    output logic             OVR
);

    typedef enum logic [1:0] {IN_EMPTY, IN_STROBED, IN_FULL} inState_t;
    typedef enum logic [1:0] {OUT_EMPTY, OUT_FULL, OUT_ACKED} outState_t;

    inState_t         inState, inNext;
    outState_t        outState, outNext;
    logic [SYNC_STAGES-1:0] stbSync, ackSync;
    logic             stbHist, ackHist;
    logic [WIDTH-1:0] portDly [SYNC_STAGES];
    logic             modeQ, dirQ, portOeQ;
    logic [WIDTH-1:0] cpuDoutQ, portOutQ;
    logic             intrReqQ, intrReqNext;
    logic             ovrQ, ovrNext;
    logic             latchIn, loadOut;

    logic stbFall, stbRise, ackFall, ackRise;
    logic modeChange, inAct, outAct, rd, wr;

    assign stbFall    = stbHist & ~stbSync[SYNC_STAGES-1];
    assign stbRise    = ~stbHist & stbSync[SYNC_STAGES-1];
    assign ackFall    = ackHist & ~ackSync[SYNC_STAGES-1];
    assign ackRise    = ~ackHist & ackSync[SYNC_STAGES-1];
    assign modeChange = (MODE1_EN != modeQ) || (DIR_IN != dirQ);
    assign inAct      = MODE1_EN & DIR_IN;
    assign outAct     = MODE1_EN & ~DIR_IN;
    // Simultaneous read and write is illegal and both are dropped.
    assign rd         = CPU_RD & ~CPU_WR;
    assign wr         = CPU_WR & ~CPU_RD;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stbSync  <= '1;
            ackSync  <= '1;
            stbHist  <= 1'b1;
            ackHist  <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) portDly[i] <= '0;
            modeQ    <= 1'b0;
            dirQ     <= 1'b0;
            portOeQ  <= 1'b0;
            inState  <= IN_EMPTY;
            outState <= OUT_EMPTY;
            intrReqQ <= 1'b0;
            ovrQ     <= 1'b0;
            cpuDoutQ <= '0;
            portOutQ <= '0;
        end else begin
            stbSync  <= {stbSync[SYNC_STAGES-2:0], STB_N};
            ackSync  <= {ackSync[SYNC_STAGES-2:0], ACK_N};
            stbHist  <= stbSync[SYNC_STAGES-1];
            ackHist  <= ackSync[SYNC_STAGES-1];
            portDly[0] <= PORT_IN;
            for (int i = 1; i < SYNC_STAGES; i++) portDly[i] <= portDly[i-1];
            modeQ    <= MODE1_EN;
            dirQ     <= DIR_IN;
            portOeQ  <= MODE1_EN & ~DIR_IN;
            inState  <= inNext;
            outState <= outNext;
            intrReqQ <= intrReqNext;
            ovrQ     <= ovrNext;
            if (latchIn) cpuDoutQ <= portDly[SYNC_STAGES-1];
            if (loadOut) portOutQ <= CPU_DIN;
        end
    end

    always_comb begin
        inNext  = inState;
        outNext = outState;
        if (modeChange) begin
            inNext  = IN_EMPTY;
            outNext = OUT_EMPTY;
        end else begin
            if (inAct) begin
                case (inState)
                    IN_EMPTY:   if (stbFall) inNext = IN_STROBED;
                    IN_STROBED: if (stbFall) inNext = IN_STROBED;
                                else if (stbRise) inNext = IN_FULL;
                    IN_FULL:    if (stbFall) inNext = IN_STROBED;
                                else if (rd) inNext = IN_EMPTY;
                    default:    inNext = IN_EMPTY;
                endcase
            end
            if (outAct) begin
                if (wr) begin
                    outNext = OUT_FULL;
                end else begin
                    case (outState)
                        OUT_EMPTY: outNext = OUT_EMPTY;
                        OUT_FULL:  if (ackFall) outNext = OUT_ACKED;
                        OUT_ACKED: if (ackRise) outNext = OUT_EMPTY;
                        default:   outNext = OUT_EMPTY;
                    endcase
                end
            end
        end
    end

    always_comb begin
        latchIn     = 1'b0;
        loadOut     = 1'b0;
        ovrNext     = 1'b0;
        intrReqNext = intrReqQ;
        if (modeChange) begin
            intrReqNext = 1'b0;
        end else if (inAct) begin
            if (stbFall) begin
                latchIn     = 1'b1;
                intrReqNext = 1'b0;
                // A read landing with the new strobe consumed the old byte, so it is not an overrun.
                ovrNext     = (inState != IN_EMPTY) & ~rd;
            end else if (stbRise && inState == IN_STROBED) begin
                intrReqNext = 1'b1;
            end else if (rd && inState != IN_EMPTY) begin
                intrReqNext = 1'b0;
            end
        end else if (outAct) begin
            if (wr) begin
                loadOut     = 1'b1;
                intrReqNext = 1'b0;
            end else if (ackRise && outState == OUT_ACKED) begin
                intrReqNext = 1'b1;
            end
        end
    end

    assign IBF      = (inState != IN_EMPTY);
    assign OBF_N    = (outState != OUT_FULL);
    assign INTR     = intrReqQ & INTE;
    assign OVR      = ovrQ;
    assign CPU_DOUT = cpuDoutQ;
    assign PORT_OUT = portOutQ;
    assign PORT_OE  = portOeQ;

endmodule
